// File: rtl/rps_remote_player_if.sv
// Link-side signal bundle for the rock-paper-scissors initiator board.
// The slave modport belongs to the player; master is the peer/host side.
interface rps_remote_player_if #(
  parameter int TALLY_W = 8
);
  logic               start;
  logic [1:0]         move;
  logic [2:0]         score_in;
  logic [2:0]         move_n;
  logic               busy;
  logic               result_valid;
  logic [1:0]         result;
  logic               error;
  logic [TALLY_W-1:0] wins;
  logic [TALLY_W-1:0] losses;
  logic [TALLY_W-1:0] ties;

  modport master (
    output start, move, score_in,
    input  move_n, busy, result_valid, result, error, wins, losses, ties
  );

  modport slave (
    input  start, move, score_in,
    output move_n, busy, result_valid, result, error, wins, losses, ties
  );
endinterface

// File: rtl/rps_remote_player.sv
// Plays one rock-paper-scissors round against a peer board: presses a move line,
// waits for the peer's score lines to settle, decodes and tallies the outcome.
module rps_remote_player #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int TALLY_W        = 8
) (
  input logic               CLK,
  input logic               RST,
  rps_remote_player_if.slave bus
);

  localparam int CNT_MAX = (SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STB_W   = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [STB_W-1:0] STABLE_DONE = STB_W'(STABLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_SAMPLE,
    S_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         move_q, move_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STB_W-1:0]   stable_q, stable_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [2:0]         prev_q, prev_d;
  logic [2:0]         meta_q, sync_q;
  logic [1:0]         result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               error_q, error_d;
  logic [2:0]         inc_d;
  logic [TALLY_W-1:0] tally_q [3];
  logic [TALLY_W-1:0] tally_d [3];
  logic [2:0]         move_n_c;
  logic               busy_c;
  logic               score_valid;
  logic [1:0]         prev_code;

  function automatic logic [1:0] code_of(input logic [2:0] s);
    logic [1:0] c;
    c = 2'd0;
    case (s)
      3'b001:  c = 2'd1;
      3'b010:  c = 2'd2;
      3'b100:  c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  // Peer score lines are asynchronous to us.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_q <= 3'b000;
      sync_q <= 3'b000;
    end else begin
      meta_q <= bus.score_in;
      sync_q <= meta_q;
    end
  end

  assign score_valid = (code_of(sync_q) != 2'd0);
  assign prev_code   = code_of(prev_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      move_q         <= 2'd0;
      cnt_q          <= '0;
      stable_q       <= '0;
      tmo_q          <= '0;
      prev_q         <= 3'b000;
      result_q       <= 2'd0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      move_q         <= move_d;
      cnt_q          <= cnt_d;
      stable_q       <= stable_d;
      tmo_q          <= tmo_d;
      prev_q         <= prev_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    move_d         = move_q;
    cnt_d          = cnt_q;
    stable_d       = stable_q;
    tmo_d          = tmo_q;
    prev_d         = prev_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    error_d        = 1'b0;
    inc_d          = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.move != 2'd0)) begin
          move_d  = bus.move;
          cnt_d   = '0;
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          stable_d = '0;
          tmo_d    = '0;
          state_d  = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        prev_d = sync_q;
        tmo_d  = tmo_q + 1'b1;
        // A completed stable run takes priority over a coincident timeout.
        if (stable_q == STABLE_DONE) begin
          result_valid_d = 1'b1;
          result_d       = prev_code;
          inc_d          = {prev_code == 2'd3, prev_code == 2'd2, prev_code == 2'd1};
          cnt_d          = '0;
          state_d        = S_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (!score_valid) begin
          stable_d = '0;
        end else if (sync_q == prev_q) begin
          stable_d = stable_q + 1'b1;
        end else begin
          stable_d = STB_W'(1);
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    move_n_c = 3'b111;
    busy_c   = (state_q != S_IDLE);
    if ((state_q == S_PRESS) || (state_q == S_SAMPLE)) begin
      case (move_q)
        2'd1:    move_n_c = 3'b110;
        2'd2:    move_n_c = 3'b101;
        2'd3:    move_n_c = 3'b011;
        default: move_n_c = 3'b111;
      endcase
    end
  end

  // Index 0 = wins, 1 = losses, 2 = ties; each saturates at all-ones.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_tally
      assign tally_d[gi] = (inc_d[gi] && (tally_q[gi] != {TALLY_W{1'b1}}))
                         ? tally_q[gi] + 1'b1 : tally_q[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        tally_q[i] <= '0;
      end
    end else begin
      tally_q <= tally_d;
    end
  end

  assign bus.move_n       = move_n_c;
  assign bus.busy         = busy_c;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.error        = error_q;
  assign bus.wins         = tally_q[0];
  assign bus.losses       = tally_q[1];
  assign bus.ties         = tally_q[2];

endmodule
